// File: rtl/sdram_burst_writer_if.sv
// Bus bundle for sdram_burst_writer: job control, arbiter handshake, SDRAM command bus, write-FIFO port.
// SDRAM_WR_BYTE_MASK_EN widens the FIFO word with per-byte masks and adds wr_dqm.
interface sdram_burst_writer_if #(
    parameter int DQ_W  = 16,
    parameter int ROW_W = 13,
    parameter int COL_W = 9,
    parameter int BA_W  = 2,
    parameter int LEN_W = 16
);
`ifdef SDRAM_WR_BYTE_MASK_EN
    localparam int FIFO_W = DQ_W + DQ_W / 8;
`else
    localparam int FIFO_W = DQ_W;
`endif

    logic                        start;
    logic [BA_W+ROW_W+COL_W-1:0] start_addr;
    logic [LEN_W-1:0]            start_len;
    logic                        busy;
    logic                        done;
    logic                        aref_req;
    logic                        wr_en;
    logic                        wr_req;
    logic                        flag_wr_end;
    logic [3:0]                  wr_cmd;
    logic [BA_W-1:0]             wr_ba;
    logic [ROW_W-1:0]            wr_addr;
    logic [DQ_W-1:0]             wr_data;
    logic                        wfifo_rd_en;
    logic [FIFO_W-1:0]           wfifo_rd_data;
`ifdef SDRAM_WR_BYTE_MASK_EN
    logic [DQ_W/8-1:0]           wr_dqm;
`endif

    modport master (
        input  start, start_addr, start_len, aref_req, wr_en, wfifo_rd_data,
        output busy, done, wr_req, flag_wr_end, wr_cmd, wr_ba, wr_addr, wr_data, wfifo_rd_en
`ifdef SDRAM_WR_BYTE_MASK_EN
        , output wr_dqm
`endif
    );

    modport slave (
        output start, start_addr, start_len, aref_req, wr_en, wfifo_rd_data,
        input  busy, done, wr_req, flag_wr_end, wr_cmd, wr_ba, wr_addr, wr_data, wfifo_rd_en
`ifdef SDRAM_WR_BYTE_MASK_EN
        , input wr_dqm
`endif
    );
endinterface

// File: rtl/sdram_burst_writer.sv
// SDRAM write engine: streams write-FIFO data as back-to-back bursts with row/bank crossing and refresh yield.
// Optional byte masking via SDRAM_WR_BYTE_MASK_EN (adds wr_dqm, FIFO word carries masks).
module sdram_burst_writer #(
    parameter int DQ_W      = 16,
    parameter int ROW_W     = 13,
    parameter int COL_W     = 9,
    parameter int BA_W      = 2,
    parameter int BURST_LEN = 4,
    parameter int LEN_W     = 16,
    parameter int T_RCD     = 2,
    parameter int T_WR      = 2,
    parameter int T_RP      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sdram_burst_writer_if.master bus
);
    localparam int CNT_W = 8;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PALL  = 4'b0010;
    localparam logic [ROW_W-1:0] ADDR_A10 = ROW_W'(1024);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_ACT, S_TRCD, S_WRITE, S_TWR, S_PRE, S_TRP
    } state_t;

    state_t             state_q, state_d;
    logic [BA_W-1:0]    bank_q, bank_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               yield_q, yield_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wr_req_q, wr_req_d;
    logic               flag_q, flag_d;
    logic [3:0]         cmd_q, cmd_d;
    logic [BA_W-1:0]    ba_q, ba_d;
    logic [ROW_W-1:0]   addr_q, addr_d;

    logic               col_carry, row_carry;
    logic [COL_W-1:0]   col_next;
    logic [ROW_W-1:0]   row_next;
    logic               enter_write, after_rp;

    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        row_d    = row_q;
        col_d    = col_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        yield_d  = yield_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        flag_d   = 1'b0;
        wr_req_d = 1'b0;
        cmd_d    = CMD_NOP;
        ba_d     = ba_q;
        addr_d   = addr_q;
        enter_write = 1'b0;
        after_rp    = 1'b0;
        {col_carry, col_next} = {1'b0, col_q} + (COL_W+1)'(BURST_LEN);
        {row_carry, row_next} = {1'b0, row_q} + (ROW_W+1)'(1);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.start_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        bank_d   = bus.start_addr[BA_W+ROW_W+COL_W-1:ROW_W+COL_W];
                        row_d    = bus.start_addr[ROW_W+COL_W-1:COL_W];
                        col_d    = bus.start_addr[COL_W-1:0] & ~COL_W'(BURST_LEN-1);
                        rem_d    = bus.start_len;
                        yield_d  = 1'b0;
                        busy_d   = 1'b1;
                        wr_req_d = 1'b1;
                        state_d  = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.wr_en) begin
                    state_d = S_ACT;
                    cmd_d   = CMD_ACT;
                    ba_d    = bank_q;
                    addr_d  = row_q;
                end else begin
                    wr_req_d = 1'b1;
                end
            end
            S_ACT: begin
                if (T_RCD == 1) begin
                    enter_write = 1'b1;
                end else begin
                    state_d = S_TRCD;
                    cnt_d   = CNT_W'(T_RCD - 2);
                end
            end
            S_TRCD: begin
                if (cnt_q == '0) enter_write = 1'b1;
                else             cnt_d = cnt_q - CNT_W'(1);
            end
            S_WRITE: begin
                // Refresh and row end are only honoured at the last beat so bursts are never cut short.
                if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                    rem_d = rem_q - LEN_W'(1);
                    col_d = col_next;
                    if (col_carry) begin
                        row_d = row_next;
                        if (row_carry) bank_d = bank_q + BA_W'(1);
                    end
                    if (rem_q == LEN_W'(1) || col_carry || bus.aref_req) begin
                        state_d = S_TWR;
                        cnt_d   = CNT_W'(T_WR - 1);
                        yield_d = bus.aref_req;
                    end else begin
                        cnt_d  = '0;
                        cmd_d  = CMD_WRITE;
                        addr_d = {{(ROW_W-COL_W){1'b0}}, col_next};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_TWR: begin
                if (cnt_q == '0) begin
                    state_d = S_PRE;
                    cmd_d   = CMD_PALL;
                    addr_d  = ADDR_A10;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PRE: begin
                if (T_RP == 1) begin
                    after_rp = 1'b1;
                end else begin
                    state_d = S_TRP;
                    cnt_d   = CNT_W'(T_RP - 2);
                end
            end
            S_TRP: begin
                if (cnt_q == '0) after_rp = 1'b1;
                else             cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_write) begin
            state_d = S_WRITE;
            cnt_d   = '0;
            cmd_d   = CMD_WRITE;
            ba_d    = bank_q;
            addr_d  = {{(ROW_W-COL_W){1'b0}}, col_q};
        end

        // After precharge: finish, hand the bus to refresh, or open the next row ourselves.
        if (after_rp) begin
            yield_d = 1'b0;
            if (rem_q == '0) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                flag_d  = 1'b1;
                busy_d  = 1'b0;
            end else if (yield_q || bus.aref_req) begin
                state_d  = S_REQ;
                wr_req_d = 1'b1;
                flag_d   = 1'b1;
            end else begin
                state_d = S_ACT;
                cmd_d   = CMD_ACT;
                ba_d    = bank_q;
                addr_d  = row_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            bank_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            yield_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_req_q <= 1'b0;
            flag_q   <= 1'b0;
            cmd_q    <= CMD_NOP;
            ba_q     <= '0;
            addr_q   <= ADDR_A10;
        end else begin
            state_q  <= state_d;
            bank_q   <= bank_d;
            row_q    <= row_d;
            col_q    <= col_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            yield_q  <= yield_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_req_q <= wr_req_d;
            flag_q   <= flag_d;
            cmd_q    <= cmd_d;
            ba_q     <= ba_d;
            addr_q   <= addr_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.wr_req      = wr_req_q;
    assign bus.flag_wr_end = flag_q;
    assign bus.wr_cmd      = cmd_q;
    assign bus.wr_ba       = ba_q;
    assign bus.wr_addr     = addr_q;
    assign bus.wr_data     = bus.wfifo_rd_data[DQ_W-1:0];
    // FIFO has one clock of read latency, so read whenever the next cycle is a write beat.
    assign bus.wfifo_rd_en = (state_d == S_WRITE);
`ifdef SDRAM_WR_BYTE_MASK_EN
    assign bus.wr_dqm = (state_q == S_WRITE) ? bus.wfifo_rd_data[DQ_W +: DQ_W/8] : '1;
`endif
endmodule

// File: tb/tb_sdram_burst_writer.sv
// Self-checking bench for sdram_burst_writer: transaction-level command model, FIFO model and arbiter model.
module tb_sdram_burst_writer;
    localparam int DQ_W = 16, ROW_W = 13, COL_W = 9, BA_W = 2, BL = 4, LEN_W = 16;
    localparam int T_RCD = 2, T_WR = 2, T_RP = 2;
    localparam int COL_MAX = (1 << COL_W) - 1;
    localparam int ROW_MAX = (1 << ROW_W) - 1;
    localparam int NBANK = 1 << BA_W;
    localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_WR = 4'b0100, C_PALL = 4'b0010;
`ifdef SDRAM_WR_BYTE_MASK_EN
    localparam int FW = DQ_W + DQ_W / 8;
`else
    localparam int FW = DQ_W;
`endif

    typedef struct { logic [3:0] cmd; int ba; int addr; bit chk_ba; int gap; } exp_t;
    typedef struct { logic [3:0] cmd; int ba; int addr; } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    obs_t obs[$];
    int   done_cnt, flag_cnt, req_cycles, rd_idx, exp_idx, cyc, prev_cyc, beats_left;
    bit   have_prev, rd_s;

    sdram_burst_writer_if #(.DQ_W(DQ_W), .ROW_W(ROW_W), .COL_W(COL_W), .BA_W(BA_W), .LEN_W(LEN_W)) bus ();

    sdram_burst_writer #(
        .DQ_W(DQ_W), .ROW_W(ROW_W), .COL_W(COL_W), .BA_W(BA_W), .BURST_LEN(BL),
        .LEN_W(LEN_W), .T_RCD(T_RCD), .T_WR(T_WR), .T_RP(T_RP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] pat(input int i);
        logic [DQ_W-1:0] d;
        d = DQ_W'(32'h1234 + i * 32'h0101);
`ifdef SDRAM_WR_BYTE_MASK_EN
        return {(DQ_W/8)'(i), d};
`else
        return d;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic int obsField(input int i, input int f);
        if (obs.size() <= i) return -1;
        case (f)
            0: return int'(obs[i].cmd);
            1: return obs[i].ba;
            default: return obs[i].addr;
        endcase
    endfunction

    task automatic pushCmd(input logic [3:0] c, input int ba, input int addr, input bit chk_ba, input int gap);
        exp_t e;
        e.cmd = c; e.ba = ba; e.addr = addr; e.chk_ba = chk_ba; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Job expressed as rows of bursts; yield_burst is the burst index at whose end refresh takes the bus.
    task automatic modelJob(input int ba, input int row, input int col, input int len,
                            input int yield_burst, output int exp_flags);
        int b, r, c, rem, burst, g;
        bit yielded, first, leave, wrap;
        b = ba; r = row; c = col - (col % BL); rem = len; burst = 0;
        yielded = 0; first = 1; exp_flags = 0;
        while (rem > 0) begin
            pushCmd(C_ACT, b, r, 1, first ? 0 : (yielded ? T_RP + 3 : T_RP));
            first = 0; leave = 0; g = T_RCD;
            while (!leave) begin
                pushCmd(C_WR, b, c, 1, g);
                g = BL; rem--; c += BL; wrap = 0;
                if (c > COL_MAX) begin
                    c = 0; wrap = 1; r++;
                    if (r > ROW_MAX) begin r = 0; b = (b + 1) % NBANK; end
                end
                yielded = (burst == yield_burst);
                burst++;
                leave = (rem == 0) || wrap || yielded;
            end
            pushCmd(C_PALL, 0, 1024, 0, BL + T_WR);
            if (rem == 0 || yielded) exp_flags++;
        end
    endtask

    // Arbiter: grants for one cycle on the third cycle of a request.
    initial begin
        int age;
        age = 0;
        bus.wr_en = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || !bus.wr_req) age = 0;
            else age++;
            bus.wr_en = (age == 3);
        end
    end

    // Write FIFO with one clock read latency.
    initial begin
        bus.wfifo_rd_data = '0;
        forever begin
            @(negedge clk);
            rd_s = bus.wfifo_rd_en;
            @(posedge clk);
            if (rd_s) begin
                bus.wfifo_rd_data = pat(rd_idx);
                rd_idx++;
            end
        end
    end

    // Compare process: command stream, command spacing, and beat data against the model.
    always @(negedge clk) begin
        logic [FW-1:0] pv;
        exp_t e;
        obs_t o;
        if (!rst_n) begin
            beats_left = 0;
            have_prev  = 0;
        end else begin
            cyc++;
            if (bus.done) done_cnt++;
            if (bus.flag_wr_end) flag_cnt++;
            if (bus.wr_req) req_cycles++;
            if (bus.wr_cmd != C_NOP) begin
                o.cmd = bus.wr_cmd; o.ba = int'(bus.wr_ba); o.addr = int'(bus.wr_addr);
                obs.push_back(o);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_cmd", 32'(bus.wr_cmd), 32'(C_NOP));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("cmd", 32'(bus.wr_cmd), 32'(e.cmd));
                    checkOutput("cmd_addr", 32'(bus.wr_addr), 32'(e.addr));
                    if (e.chk_ba) checkOutput("cmd_ba", 32'(bus.wr_ba), 32'(e.ba));
                    if (e.gap != 0 && have_prev) checkOutput("cmd_gap", 32'(cyc - prev_cyc), 32'(e.gap));
                end
                prev_cyc  = cyc;
                have_prev = 1;
                if (bus.wr_cmd == C_WR) beats_left = BL;
            end
            if (beats_left > 0) begin
                pv = pat(exp_idx);
                checkOutput("beat_data", 32'(bus.wr_data), 32'(pv[DQ_W-1:0]));
`ifdef SDRAM_WR_BYTE_MASK_EN
                checkOutput("beat_dqm", 32'(bus.wr_dqm), 32'(pv[FW-1:DQ_W]));
`endif
                exp_idx++;
                beats_left--;
            end
        end
    end

    task automatic clearLogs();
        exp_q.delete(); obs.delete();
        done_cnt = 0; flag_cnt = 0; req_cycles = 0; rd_idx = 0; exp_idx = 0;
    endtask

    task automatic pulseStart(input int ba, input int row, input int col, input int len);
        bus.start_addr = {BA_W'(ba), ROW_W'(row), COL_W'(col)};
        bus.start_len  = LEN_W'(len);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Runs one job to completion; aref_after raises refresh once that many commands have been seen.
    task automatic applyStimulus(input string tag, input int ba, input int row, input int col, input int len,
                                 input int yield_burst, input int aref_after, input bit poke);
        int exp_flags;
        bit raised;
        clearLogs();
        modelJob(ba, row, col, len, yield_burst, exp_flags);
        raised = 0;
        pulseStart(ba, row, col, len);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
        for (int n = 0; n < 400 && done_cnt == 0; n++) begin
            if (aref_after >= 0 && !raised && obs.size() == aref_after) begin
                bus.aref_req = 1'b1;
                raised = 1;
            end
            if (bus.aref_req && flag_cnt > 0) bus.aref_req = 1'b0;
            if (poke && n == 4) begin
                bus.start_addr = '0; bus.start_len = LEN_W'(3); bus.start = 1'b1;
            end
            if (poke && n == 5) bus.start = 1'b0;
            @(posedge clk); #1;
        end
        bus.aref_req = 1'b0;
        checkOutput({tag, "_done_in_time"}, 32'(done_cnt > 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        checkOutput({tag, "_flag_pulses"}, 32'(flag_cnt), 32'(exp_flags));
        checkOutput({tag, "_cmds_left"}, 32'(exp_q.size()), 32'd0);
        checkOutput({tag, "_fifo_reads"}, 32'(rd_idx), 32'(len * BL));
        checkOutput({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cmd"}, 32'(bus.wr_cmd), 32'(C_NOP));
        checkOutput({tag, "_addr"}, 32'(bus.wr_addr), 32'h400);
        checkOutput({tag, "_ba"}, 32'(bus.wr_ba), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_wr_req"}, 32'(bus.wr_req), 32'd0);
        checkOutput({tag, "_rd_en"}, 32'(bus.wfifo_rd_en), 32'd0);
        checkOutput({tag, "_done_flag"}, 32'({bus.done, bus.flag_wr_end}), 32'd0);
    endtask

    initial begin
        int n;
        bus.start = 1'b0; bus.start_addr = '0; bus.start_len = '0; bus.aref_req = 1'b0;
        cyc = 0; rd_idx = 0; clearLogs();
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: two bursts in row 0
        applyStimulus("t1", 0, 0, 0, 2, -1, -1, 0);
        checkOutput("t1_n_cmds", 32'(obs.size()), 32'd4);
        checkOutput("t1_act_row", 32'(obsField(0, 2)), 32'd0);
        checkOutput("t1_wr0_col", 32'(obsField(1, 2)), 32'd0);
        checkOutput("t1_wr1_col", 32'(obsField(2, 2)), 32'd4);
        checkOutput("t1_pall", 32'(obsField(3, 0)), 32'(C_PALL));
        checkOutput("t1_reads", 32'(rd_idx), 32'd8);

        // 2: last burst of row 5 then next row
        applyStimulus("t2", 1, 5, COL_MAX - 3, 2, -1, -1, 0);
        checkOutput("t2_wr_col", 32'(obsField(1, 2)), 32'd508);
        checkOutput("t2_act_row6", 32'(obsField(3, 2)), 32'd6);
        checkOutput("t2_wr_col0", 32'(obsField(4, 2)), 32'd0);
        checkOutput("t2_flags", 32'(flag_cnt), 32'd1);

        // 3: refresh yield after burst 1, resume at col 8
        applyStimulus("t3", 0, 3, 0, 4, 1, 3, 0);
        checkOutput("t3_pall_after_b1", 32'(obsField(3, 0)), 32'(C_PALL));
        checkOutput("t3_resume_act", 32'(obsField(4, 2)), 32'd3);
        checkOutput("t3_resume_col", 32'(obsField(5, 2)), 32'd8);
        checkOutput("t3_flags", 32'(flag_cnt), 32'd2);

        // 4: zero-length job, then start while busy
        clearLogs();
        pulseStart(2, 7, 40, 0);
        checkOutput("t4_len0_done", 32'(bus.done), 32'd1);
        checkOutput("t4_len0_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        checkOutput("t4_len0_done_clr", 32'(bus.done), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("t4_len0_no_req", 32'(req_cycles), 32'd0);
        applyStimulus("t4", 2, 7, 40, 1, -1, -1, 1);
        checkOutput("t4_act_bank", 32'(obsField(0, 1)), 32'd2);
        checkOutput("t4_wr_col", 32'(obsField(1, 2)), 32'd40);

        // 5: row and bank wrap
        applyStimulus("t5", 3, ROW_MAX, COL_MAX - 3, 2, -1, -1, 0);
        checkOutput("t5_wrap_bank", 32'(obsField(3, 1)), 32'd0);
        checkOutput("t5_wrap_row", 32'(obsField(3, 2)), 32'd0);

        // 6: reset during a write burst, then a fresh job
        clearLogs();
        begin
            int dummy;
            modelJob(2, 10, 0, 4, -1, dummy);
        end
        pulseStart(2, 10, 0, 4);
        n = 0;
        while (obs.size() < 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("t6_reached_write", 32'(obs.size() >= 2), 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetValues("t6_abort");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus("t6_fresh", 1, 100, 18, 1, -1, -1, 0);
        checkOutput("t6_fresh_col", 32'(obsField(1, 2)), 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
